// File: rtl/life_pkg.sv
// Shared types and constants for the life arena sequencer: FSM state encoding,
// seed stepping constant and generation counter width.
package life_pkg;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_SEED_REQ  = 3'd1,
        ST_SEED_WAIT = 3'd2,
        ST_IDLE      = 3'd3,
        ST_GEN_START = 3'd4,
        ST_GEN_WAIT  = 3'd5
    } state_e;

    localparam int unsigned GEN_W     = 16;
    localparam logic [31:0] SEED_STEP = 32'h9E37_79B9;

    // An all-zero seed would stall the seeder's LFSR, so a wrap falls back to the init seed.
    function automatic logic [31:0] next_seed(input logic [31:0] cur, input logic [31:0] init);
        logic [31:0] sum;
        sum = cur + SEED_STEP;
        return (sum == '0) ? init : sum;
    endfunction

endpackage

// File: rtl/life_sequencer_gen_timer.sv
// Pacing counter for life_sequencer: counts while run is high, saturates at
// TICKS_PER_GEN-1 and flags expiry there; clear has priority.
module gen_timer #(
    parameter int unsigned TICKS_PER_GEN = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned      CNT_W = $clog2(TICKS_PER_GEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS_PER_GEN - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/life_sequencer.sv
// Sequences the seeder and generation engine: seeds after reset/reseed, then
// launches generations per timer period or step. Optional: LIFE_SEQ_AUTO_RESEED_EN.
module life_sequencer
    import life_pkg::*;
#(
    parameter int unsigned TICKS_PER_GEN    = 1_000_000,
    parameter logic [31:0] SEED_INIT        = 32'hACE1_2345,
    parameter int unsigned AUTO_RESEED_GENS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        reseed,
    output logic        seeder_start,
    input  logic        seeder_ready,
    output logic [31:0] seed,
    output logic        gen_start,
    input  logic        gen_done,
    output logic [15:0] generation,
    output logic        busy
);

    state_e             state_q, state_d;
    logic [31:0]        seed_q, seed_d;
    logic [GEN_W-1:0]   gen_q, gen_d, gen_inc;
    logic               seeder_start_q, seeder_start_d;
    logic               gen_start_q, gen_start_d;
    logic               reseed_pend_q, reseed_pend_d;
    logic               step_pend_q, step_pend_d;
    logic               reseed_clr, step_clr;
    logic               timer_clear, timer_expired;
    logic               auto_hit;

    gen_timer #(
        .TICKS_PER_GEN(TICKS_PER_GEN)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .clear  (timer_clear),
        .expired(timer_expired)
    );

    assign gen_inc = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);

`ifdef LIFE_SEQ_AUTO_RESEED_EN
    assign auto_hit = (state_q == ST_GEN_WAIT) && gen_done
                      && (gen_inc == GEN_W'(AUTO_RESEED_GENS));
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        seed_d         = seed_q;
        gen_d          = gen_q;
        seeder_start_d = 1'b0;
        gen_start_d    = 1'b0;
        timer_clear    = 1'b0;
        reseed_clr     = 1'b0;
        step_clr       = 1'b0;

        unique case (state_q)
            ST_BOOT: state_d = ST_SEED_REQ;
            ST_SEED_REQ: begin
                if (seeder_ready) begin
                    seeder_start_d = 1'b1;
                    state_d        = ST_SEED_WAIT;
                end
            end
            ST_SEED_WAIT: begin
                // seeder_start_q is high exactly in the first SEED_WAIT cycle, while ready is still stale.
                if (!seeder_start_q && seeder_ready) begin
                    gen_d      = '0;
                    reseed_clr = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (reseed_pend_q) begin
                    seed_d  = next_seed(seed_q, SEED_INIT);
                    state_d = ST_SEED_REQ;
                end else if (step_pend_q || (run && timer_expired)) begin
                    gen_start_d = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = ST_GEN_START;
                end
            end
            ST_GEN_START: begin
                step_clr = 1'b1;
                state_d  = ST_GEN_WAIT;
            end
            ST_GEN_WAIT: begin
                if (gen_done) begin
                    gen_d   = gen_inc;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        reseed_pend_d = (reseed_pend_q & ~reseed_clr) | reseed | auto_hit;
        step_pend_d   = (step_pend_q & ~step_clr) | (step & ~run);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_BOOT;
            seed_q         <= SEED_INIT;
            gen_q          <= '0;
            seeder_start_q <= 1'b0;
            gen_start_q    <= 1'b0;
            reseed_pend_q  <= 1'b0;
            step_pend_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            gen_q          <= gen_d;
            seeder_start_q <= seeder_start_d;
            gen_start_q    <= gen_start_d;
            reseed_pend_q  <= reseed_pend_d;
            step_pend_q    <= step_pend_d;
        end
    end

    assign seeder_start = seeder_start_q;
    assign gen_start    = gen_start_q;
    assign seed         = seed_q;
    assign generation   = gen_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer: boot/step vector table followed by
// directed sequences for pacing, step collapsing, reseed priority, seed wrap and reset.
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, step, reseed, seeder_ready, gen_done;
    logic        seeder_start, gen_start, busy;
    logic [31:0] seed;
    logic [15:0] generation;

    logic        w_run, w_step, w_reseed, w_ready, w_done;
    logic        w_ss, w_gs, w_busy;
    logic [31:0] w_seed;
    logic [15:0] w_gen;

    always #5 clk = ~clk;

    life_sequencer #(
        .TICKS_PER_GEN   (8),
        .SEED_INIT       (32'hACE1_2345),
        .AUTO_RESEED_GENS(1000)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .reseed(reseed),
        .seeder_start(seeder_start), .seeder_ready(seeder_ready), .seed(seed),
        .gen_start(gen_start), .gen_done(gen_done), .generation(generation), .busy(busy)
    );

    // 32'hC391_0C8E + 2*32'h9E37_79B9 wraps to exactly zero.
    life_sequencer #(
        .TICKS_PER_GEN   (8),
        .SEED_INIT       (32'hC391_0C8E),
        .AUTO_RESEED_GENS(4)
    ) dut_w (
        .clk(clk), .reset(reset), .run(w_run), .step(w_step), .reseed(w_reseed),
        .seeder_start(w_ss), .seeder_ready(w_ready), .seed(w_seed),
        .gen_start(w_gs), .gen_done(w_done), .generation(w_gen), .busy(w_busy)
    );

    typedef struct {
        logic        rst, rdy, stp, rsd, done;
        logic        ss, gs, bsy;
        logic [15:0] gen;
        logic [31:0] sd;
    } vec_t;

    int checks = 0, failures = 0;
    int cyc = 0, gs_cnt = 0, ss_cnt = 0, done_cnt = 0, w_ss_cnt = 0;
    int cd = 0, scd = 0, eng_lat = 3;
    int gs_times[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; engine and seeder models respond to the sampled pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (w_ss) w_ss_cnt++;
        if (gen_start) begin
            gs_cnt++;
            gs_times.push_back(cyc);
            cd = eng_lat - 1;
            gen_done = 1'b0;
        end else if (cd != 0) begin
            cd--;
            gen_done = (cd == 0);
            if (cd == 0) done_cnt++;
        end else begin
            gen_done = 1'b0;
        end
        if (seeder_start) begin
            ss_cnt++;
            scd = 3;
            seeder_ready = 1'b1;
        end else if (scd != 0) begin
            scd--;
            seeder_ready = (scd == 0);
        end
    endtask

    task automatic wait_gs(input string nm);
        int n = 0;
        while (gen_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(nm, gen_start, 1'b1);
    endtask

    task automatic w_step_gen();
        w_step = 1'b1; tick();
        w_step = 1'b0; tick();
        tick();
        w_done = 1'b1; tick();
        w_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   base_gs, base_ss, base_done, base_wss;

        //             rst   rdy   stp   rsd   done  ss    gs    bsy   gen    seed
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'hACE1_2345};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'hACE1_2345};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 32'hACE1_2345};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'hACE1_2345};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'hACE1_2345};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'hACE1_2345};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'hACE1_2345};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'hACE1_2345};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'hACE1_2345};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'hACE1_2345};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'hACE1_2345};

        reset = 1'b1; run = 1'b0; step = 1'b0; reseed = 1'b0;
        seeder_ready = 1'b1; gen_done = 1'b0;
        w_run = 1'b0; w_step = 1'b0; w_reseed = 1'b0; w_ready = 1'b1; w_done = 1'b0;

        // Boot, seeder handshake with stale-ready skip, one stepped generation.
        for (int i = 0; i < 11; i++) begin
            reset        = vecs[i].rst;
            seeder_ready = vecs[i].rdy;
            step         = vecs[i].stp;
            reseed       = vecs[i].rsd;
            gen_done     = vecs[i].done;
            @(posedge clk);
            #1;
            cyc++;
            chk($sformatf("vec%0d", i), {seeder_start, gen_start, busy, generation, seed},
                {vecs[i].ss, vecs[i].gs, vecs[i].bsy, vecs[i].gen, vecs[i].sd});
        end
        step = 1'b0; gen_done = 1'b0; seeder_ready = 1'b1;

        // Free-running: launches every 8 cycles, generation 1 -> 6.
        eng_lat = 3;
        gs_times.delete();
        base_gs = gs_cnt;
        run = 1'b1;
        for (int k = 0; k < 80 && (gs_cnt - base_gs) < 5; k++) tick();
        run = 1'b0;
        repeat (6) tick();
        chk("run_launches", gs_cnt - base_gs, 5);
        if (gs_times.size() >= 5)
            for (int k = 1; k < 5; k++)
                chk($sformatf("run_period%0d", k), gs_times[k] - gs_times[k-1], 8);
        chk("run_gen", generation, 6);

        // Two step pulses during a long GEN_WAIT collapse into one extra launch.
        eng_lat = 6;
        base_gs = gs_cnt;
        step = 1'b1; tick();
        step = 1'b0;
        wait_gs("step_first_launch");
        tick();
        step = 1'b1; tick();
        step = 1'b0; tick();
        step = 1'b1; tick();
        step = 1'b0;
        repeat (16) tick();
        chk("step_collapse_launches", gs_cnt - base_gs, 2);
        chk("step_collapse_gen", generation, 8);

        // Step while running is dropped (one run cycle leaves the timer at 1).
        base_gs = gs_cnt;
        run = 1'b1; step = 1'b1; tick();
        run = 1'b0; step = 1'b0;
        repeat (12) tick();
        chk("step_while_run", gs_cnt - base_gs, 0);

        // Reseed pending and timer expiry on the same IDLE edge: reseed wins.
        base_gs = gs_cnt;
        base_ss = ss_cnt;
        run = 1'b1;
        repeat (5) tick();
        reseed = 1'b1; tick();
        reseed = 1'b0; tick();
        run = 1'b0;
        chk("prio_busy", busy, 1'b1);
        chk("prio_seed", seed, 32'h4B18_9CFE);
        repeat (10) tick();
        chk("prio_no_launch", gs_cnt - base_gs, 0);
        chk("prio_seeder_start", ss_cnt - base_ss, 1);
        chk("prio_gen_cleared", generation, 0);
        chk("prio_idle", busy, 1'b0);
        chk("prio_seed_hold", seed, 32'h4B18_9CFE);

        // Reset while in GEN_WAIT returns to BOOT and seeds again.
        step = 1'b1; tick();
        step = 1'b0;
        wait_gs("rst_pre_launch");
        repeat (8) tick();
        chk("rst_pre_gen", generation, 1);
        step = 1'b1; tick();
        step = 1'b0;
        wait_gs("rst_launch");
        tick();
        reset = 1'b1; cd = 0; gen_done = 1'b0;
        tick();
        chk("rst_state", {busy, gen_start, seeder_start, generation, seed},
            {1'b1, 1'b0, 1'b0, 16'd0, 32'hACE1_2345});
        reset = 1'b0;
        tick();
        chk("rst_cycle1_no_start", seeder_start, 1'b0);
        tick();
        chk("rst_cycle2_start", seeder_start, 1'b1);
        repeat (8) tick();
        chk("rst_back_idle", busy, 1'b0);

        // Seed wrap on the second instance: C3910C8E -> 61C88647 -> 0 -> SEED_INIT.
        w_reseed = 1'b1; tick();
        w_reseed = 1'b0;
        repeat (8) tick();
        chk("wrap_first", {w_busy, w_seed}, {1'b0, 32'h61C8_8647});
        w_reseed = 1'b1; tick();
        w_reseed = 1'b0;
        repeat (8) tick();
        chk("wrap_to_init", {w_busy, w_seed}, {1'b0, 32'hC391_0C8E});

        // Automatic reseed after generation 4 only when the feature is built in.
        base_wss = w_ss_cnt;
        repeat (4) w_step_gen();
        repeat (10) tick();
`ifdef LIFE_SEQ_AUTO_RESEED_EN
        chk("auto_seeder_start", w_ss_cnt - base_wss, 1);
        chk("auto_gen", w_gen, 0);
        chk("auto_seed", w_seed, 32'h61C8_8647);
`else
        chk("auto_seeder_start", w_ss_cnt - base_wss, 0);
        chk("auto_gen", w_gen, 4);
        chk("auto_seed", w_seed, 32'hC391_0C8E);
`endif

        // Main instance: four timed generations from a fresh seed, no reseed.
        eng_lat = 3;
        base_ss   = ss_cnt;
        base_done = done_cnt;
        run = 1'b1;
        for (int k = 0; k < 80 && (done_cnt - base_done) < 4; k++) tick();
        run = 1'b0;
        repeat (14) tick();
        chk("main_done_count", done_cnt - base_done, 4);
        chk("main_no_auto", ss_cnt - base_ss, 0);
        chk("main_gen", generation, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
